// File: rtl/sfifo_level.sv
// sfifo_level: single-clock FIFO with fill level, programmable
// almost-full/empty thresholds, sticky error flags and FWFT option.
module sfifo_level #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 2**ASIZE-2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic             wr_overflow,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic             rd_underflow,
  input  logic             clr_err,
  output logic [ASIZE:0]   level
);

  localparam int LW = ASIZE + 1;
  localparam logic [LW-1:0] DEPTH = LW'(2**ASIZE);
  localparam logic [LW-1:0] AFT   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AET   = LW'(AE_THRESH);
  localparam logic          AF_RST = (AF_THRESH == 0);

  logic [DSIZE-1:0] mem [2**ASIZE];

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wa, ra;

  always_comb begin
    wa       = wr_inc & ~full_q;
    ra       = rd_inc & ~empty_q;
    wr_ptr_d = wr_ptr_q + LW'(wa);
    rd_ptr_d = rd_ptr_q + LW'(ra);
    level_d  = level_q + LW'(wa) - LW'(ra);
    full_d   = (level_d == DEPTH);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AFT);
    aempty_d = (level_d <= AET);
    // a new error outranks a clear on the same edge
    ovf_d    = (ovf_q & ~clr_err) | (wr_inc & full_q);
    udf_d    = (udf_q & ~clr_err) | (rd_inc & empty_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AF_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr_q[ASIZE-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem[rd_ptr_q[ASIZE-1:0]];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else if (ra) rdata_q <= mem[rd_ptr_q[ASIZE-1:0]];
      end
      assign rd_data = rdata_q;
    end
  endgenerate

  logic unused_ptr_msb;
  assign unused_ptr_msb = wr_ptr_q[ASIZE] ^ rd_ptr_q[ASIZE];

  assign wr_full         = full_q;
  assign wr_almost_full  = afull_q;
  assign wr_overflow     = ovf_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;
  assign rd_underflow    = udf_q;
  assign level           = level_q;

endmodule
